// File: rtl/cr_prefix_pfq_ctl_pkg.sv
// cr_prefixPKG: shared entry type and constants for the prefix-number queue controller.
package cr_prefixPKG;
    localparam logic [7:0] CR_PREFIX_PFQ_TMO_CODE = 8'h01;
    localparam int PFQ_DEPTH_DEF = 8;
    localparam int PFQ_TMO_CYC_DEF = 1024;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
    } pfq_entry_t;
endpackage

// File: rtl/cr_prefix_pfq_ctl_fifo.sv
// cr_prefix_pfq_fifo: flop-based show-ahead queue of prefix-number entries with occupancy.
module cr_prefix_pfq_fifo #(
    parameter int DEPTH     = 8,
    parameter int AEMPTY_TH = 1,
    parameter int W         = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       empty,
    output logic                       aempty,
    output logic [$clog2(DEPTH):0]     occ
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          rd;

    assign empty   = occ == '0;
    assign aempty  = int'(occ) <= AEMPTY_TH;
    assign rd      = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk)
        if (wr_en) mem[wptr] <= wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            occ <= occ + (AW+1)'(wr_en) - (AW+1)'(rd);
        end
    end

    // The controller's admission rule must keep the queue from ever overflowing.
    assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && occ == (AW+1)'(DEPTH)));
endmodule

// File: rtl/cr_prefix_pfq_ctl.sv
// cr_prefix_pfq_ctl: round-robin dispatch of prefix lookups to two engines and
// in-order commit of their results (or timeout entries) into the prefix-number queue.
module cr_prefix_pfq_ctl
    import cr_prefixPKG::*;
#(
    parameter int N_ENG     = 2,
    parameter int DEPTH     = PFQ_DEPTH_DEF,
    parameter int AEMPTY_TH = 1,
    parameter int TMO_CYC   = PFQ_TMO_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frm_req_valid,
    output logic               frm_req_ready,
    output logic [N_ENG-1:0]   eng_start,
    input  logic [N_ENG-1:0]   eng_done,
    input  logic [N_ENG*9-1:0] eng_result,
    output logic [8:0]         pf_data,
    output logic               pf_empty,
    output logic               pf_aempty,
    input  logic               pf_ren,
    output logic               stat_tmo
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] TMO = 16'(TMO_CYC);
    localparam pfq_entry_t TMO_ENTRY = '{err: 1'b1, code: CR_PREFIX_PFQ_TMO_CODE};

    logic [N_ENG-1:0] busy, held, waiting, tmo_hit, arrive;
    pfq_entry_t       hold_q [N_ENG];
    pfq_entry_t       arr_data [N_ENG];
    logic [15:0]      cnt [N_ENG];
    logic             dptr, cptr, wr_en;
    pfq_entry_t       wr_data;
    logic [AW:0]      occ;

    // An engine stays busy from dispatch until its entry is committed, so held
    // results still count against queue space and block redispatch.
    assign waiting = busy & ~held;

    for (genvar g = 0; g < N_ENG; g++) begin : g_eng
        assign tmo_hit[g]  = waiting[g] && cnt[g] == TMO;
        assign arrive[g]   = waiting[g] && (eng_done[g] || tmo_hit[g]);
        assign arr_data[g] = tmo_hit[g] ? TMO_ENTRY : pfq_entry_t'(eng_result[g*9 +: 9]);
    end

    assign frm_req_ready = rst_n && !busy[dptr] && (int'(occ) + $countones(busy) < DEPTH);
    assign eng_start     = (frm_req_valid && frm_req_ready) ? N_ENG'(1) << dptr : '0;
    assign stat_tmo      = |tmo_hit;
    assign wr_en         = held[cptr] || arrive[cptr];
    assign wr_data       = held[cptr] ? hold_q[cptr] : arr_data[cptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            held <= '0;
            dptr <= 1'b0;
            cptr <= 1'b0;
            for (int e = 0; e < N_ENG; e++) begin
                hold_q[e] <= '0;
                cnt[e]    <= '0;
            end
        end else begin
            if (frm_req_valid && frm_req_ready) dptr <= ~dptr;
            if (wr_en) cptr <= ~cptr;
            for (int e = 0; e < N_ENG; e++) begin
                cnt[e] <= waiting[e] ? cnt[e] + 16'd1 : 16'd0;
                if (eng_start[e]) begin
                    busy[e] <= 1'b1;
                end else if (wr_en && cptr == 1'(e)) begin
                    busy[e] <= 1'b0;
                    held[e] <= 1'b0;
                end else if (arrive[e]) begin
                    held[e]   <= 1'b1;
                    hold_q[e] <= arr_data[e];
                end
            end
        end
    end

    cr_prefix_pfq_fifo #(
        .DEPTH     (DEPTH),
        .AEMPTY_TH (AEMPTY_TH),
        .W         (9)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pf_ren),
        .rd_data (pf_data),
        .empty   (pf_empty),
        .aempty  (pf_aempty),
        .occ     (occ)
    );
endmodule

// File: tb/tb_cr_prefix_pfq_ctl.sv
// tb_cr_prefix_pfq_ctl: scoreboard bench with behavioural engines for the prefix-number queue controller.
module tb_cr_prefix_pfq_ctl;
    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    typedef struct {
        int         dly;
        logic [8:0] val;
        bit         silent;
    } plan_t;

    logic        clk = 0, rst_n = 0, frm_req_valid = 0, pf_ren = 0, spur0 = 0;
    logic        frm_req_ready, pf_empty, pf_aempty, stat_tmo;
    logic [1:0]  eng_start, eng_done;
    logic [17:0] eng_result;
    logic [8:0]  pf_data;
    int          cyc = 0, epoch = 0, total = 0, bad = 0, ren_mode = 0;
    int          nst = 0, efall = 0, afall = 0, tmo_cnt = 0, tmo_cyc = 0;
    logic        prev_e = 1, prev_a = 1;
    plan_t       plan_q[$];
    logic [8:0]  exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cr_prefix_pfq_ctl #(
        .N_ENG(2), .DEPTH(DEPTH), .AEMPTY_TH(1), .TMO_CYC(TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frm_req_valid (frm_req_valid),
        .frm_req_ready (frm_req_ready),
        .eng_start     (eng_start),
        .eng_done      (eng_done),
        .eng_result    (eng_result),
        .pf_data       (pf_data),
        .pf_empty      (pf_empty),
        .pf_aempty     (pf_aempty),
        .pf_ren        (pf_ren),
        .stat_tmo      (stat_tmo)
    );

    // Behavioural engines: each lookup answers after its planned delay, or never.
    // The expected queue entry is known the moment the lookup is dispatched.
    for (genvar g = 0; g < 2; g++) begin : eng
        logic       d = 0;
        logic [8:0] r = '0;
        int         start_cyc = 0, done_cyc = 0;
        initial begin
            forever begin
                @(negedge clk);
                if (rst_n && eng_start[g]) begin
                    plan_t p;
                    int    my;
                    my = epoch;
                    start_cyc = cyc;
                    if (plan_q.size() > 0) p = plan_q.pop_front();
                    else begin
                        p.silent = ($urandom_range(0, 9) == 0);
                        p.dly    = $urandom_range(1, 12);
                        p.val    = 9'($urandom);
                    end
                    exp_q.push_back(p.silent ? 9'h101 : p.val);
                    if (!p.silent) begin
                        for (int i = 0; i < p.dly && epoch == my; i++) @(posedge clk);
                        if (epoch == my) begin
                            #1;
                            d = 1;
                            r = p.val;
                            done_cyc = cyc;
                            @(posedge clk);
                            #1;
                            d = 0;
                        end
                    end
                end
            end
        end
    end

    assign eng_done   = {eng[1].d, eng[0].d | spur0};
    assign eng_result = {eng[1].r, eng[0].r};

    initial begin
        forever begin
            @(posedge clk);
            #2;
            pf_ren = (ren_mode == 1) || (ren_mode == 2 && $urandom_range(0, 1) == 1);
        end
    end

    // Monitor: every accepted pop must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) nst = 0;
        else if (|eng_start) nst++;
        if (prev_e && !pf_empty) efall = cyc;
        if (prev_a && !pf_aempty) afall = cyc;
        if (stat_tmo) begin
            tmo_cnt++;
            tmo_cyc = cyc;
        end
        prev_e = pf_empty;
        prev_a = pf_aempty;
        if (rst_n && pf_ren && !pf_empty) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got %h want no entry", pf_data);
            end else begin
                e = exp_q.pop_front();
                if (pf_data !== e) begin
                    bad++;
                    $display("FAIL sb_data: got %h want %h", pf_data, e);
                end
            end
        end
    end

    function automatic plan_t mk(input int d, input logic [8:0] v, input bit s);
        plan_t p;
        p.dly = d;
        p.val = v;
        p.silent = s;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue();
        int t = 0;
        frm_req_valid = 1;
        do begin
            @(negedge clk);
            t++;
        end while (!frm_req_ready && t < 300);
        if (!frm_req_ready) begin
            total++;
            bad++;
            $display("FAIL issue_wait: ready=0 want 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
        frm_req_valid = 0;
    endtask

    task automatic wait_sig(input bit aem, input int bound, input string nm);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((aem ? pf_aempty : pf_empty) && t < bound);
        if (aem ? pf_aempty : pf_empty) begin
            total++;
            bad++;
            $display("FAIL %s: still 1 after %0d cycles, want 0", nm, bound);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int t = 0;
        ren_mode = 1;
        while ((exp_q.size() != 0 || !pf_empty) && t < bound) begin
            step(1);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        ren_mode = 0;
        step(2);
    endtask

    task automatic align0();
        if (nst % 2 == 1) begin
            plan_q.push_back(mk(1, 9'h0FF, 0));
            issue();
            wait_sig(0, 50, "align");
            drain(100);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_empty"}, pf_empty, 1);
        chk({tag, "_aempty"}, pf_aempty, 1);
        chk({tag, "_data"}, pf_data, 0);
        chk({tag, "_start"}, eng_start, 0);
        chk({tag, "_ready"}, frm_req_ready, 0);
        chk({tag, "_tmo"}, stat_tmo, 0);
    endtask

    initial begin
        int t0;
        frm_req_valid = 1;
        step(3);
        chk_reset("rst");
        frm_req_valid = 0;
        rst_n = 1;

        // Single lookup on engine 0.
        plan_q.push_back(mk(3, 9'h005, 0));
        issue();
        wait_sig(0, 50, "single_wait");
        chk("single_lat", efall - eng[0].done_cyc, 1);
        chk("single_data", pf_data, 9'h005);
        drain(50);
        chk("single_pop_empty", pf_empty, 1);

        // Engine 1 answers before engine 0: order must follow dispatch.
        align0();
        plan_q.push_back(mk(6, 9'h003, 0));
        plan_q.push_back(mk(2, 9'h00A, 0));
        issue();
        issue();
        wait_sig(0, 50, "ooo_wait");
        chk("ooo_head", pf_data, 9'h003);
        drain(50);

        // Both engines done in the same cycle: two writes on consecutive cycles.
        align0();
        plan_q.push_back(mk(5, 9'h001, 0));
        plan_q.push_back(mk(4, 9'h002, 0));
        issue();
        issue();
        wait_sig(1, 50, "same_wait");
        chk("same_first", efall - eng[0].done_cyc, 1);
        chk("same_second", afall - efall, 1);
        chk("same_head", pf_data, 9'h001);
        drain(50);

        // Engine 0 silent: timeout entry, single stat_tmo pulse, late done ignored.
        align0();
        t0 = tmo_cnt;
        plan_q.push_back(mk(0, 9'h000, 1));
        issue();
        wait_sig(0, TMO + 40, "tmo_wait");
        chk("tmo_pulses", tmo_cnt - t0, 1);
        chk("tmo_when", tmo_cyc - eng[0].start_cyc, TMO + 1);
        chk("tmo_data", pf_data, 9'h101);
        drain(50);
        spur0 = 1;
        step(1);
        spur0 = 0;
        step(3);
        chk("tmo_late_done", pf_empty, 1);

        // Fill with the consumer stalled: admission stops at DEPTH.
        for (int i = 0; i < 10; i++) plan_q.push_back(mk(1 + i % 3, 9'(i * 37 + 5), 0));
        t0 = nst;
        frm_req_valid = 1;
        step(30);
        chk("full_starts", nst - t0, DEPTH);
        chk("full_ready", frm_req_ready, 0);
        frm_req_valid = 0;
        plan_q.delete();
        drain(100);
        ren_mode = 1;
        step(4);
        ren_mode = 0;
        step(2);
        chk("ren_empty_e", pf_empty, 1);
        chk("ren_empty_a", pf_aempty, 1);
        chk("ren_empty_d", pf_data, 0);
        plan_q.push_back(mk(2, 9'h1AB, 0));
        issue();
        wait_sig(0, 50, "after_empty_wait");
        drain(50);

        // Reset with both engines outstanding and 3 entries queued.
        for (int i = 0; i < 3; i++) plan_q.push_back(mk(1, 9'(9'h040 + i), 0));
        plan_q.push_back(mk(30, 9'h0EE, 0));
        plan_q.push_back(mk(30, 9'h0DD, 0));
        for (int i = 0; i < 5; i++) issue();
        step(2);
        chk("pre_rst_aempty", pf_aempty, 0);
        frm_req_valid = 1;
        rst_n = 0;
        epoch++;
        #1;
        chk_reset("mid_rst");
        exp_q.delete();
        plan_q.delete();
        step(2);
        frm_req_valid = 0;
        rst_n = 1;
        spur0 = 1;
        step(2);
        spur0 = 0;
        step(2);
        chk("post_rst_empty", pf_empty, 1);
        chk("post_rst_ready", frm_req_ready, 1);
        plan_q.push_back(mk(2, 9'h0C3, 0));
        frm_req_valid = 1;
        @(negedge clk);
        chk("post_rst_eng0", eng_start, 2'b01);
        @(posedge clk);
        #1;
        frm_req_valid = 0;
        wait_sig(0, 50, "post_rst_wait");
        chk("post_rst_data", pf_data, 9'h0C3);
        drain(50);

        // Random traffic against the scoreboard.
        ren_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            frm_req_valid = ($urandom_range(0, 2) != 0);
            step(1);
        end
        frm_req_valid = 0;
        drain(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
